// File: rtl/lstm_pkg.sv
// Shared types and helpers for the sequential LSTM cell.
// Build option: LSTM_SAT_EN selects saturating narrowing.
package lstm_pkg;

  localparam logic [1:0] GATE_F = 2'd0;
  localparam logic [1:0] GATE_I = 2'd1;
  localparam logic [1:0] GATE_C = 2'd2;
  localparam logic [1:0] GATE_O = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_MAC,
    S_ACT,
    S_UPD_C,
    S_UPD_H,
    S_OUT
  } state_t;

  function automatic int acc_width(input int dw, input int n);
    return 2 * dw + $clog2(n + 1);
  endfunction

  function automatic int waddr(input int g, input int j, input int k,
                               input int hid, input int n);
    return (g * hid + j) * (n + 1) + k;
  endfunction

  function automatic logic signed [63:0] sat_narrow(
    input logic signed [63:0] v, input int dw);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/lstm_mac_unit.sv
// Shared gate MAC: clear/accumulate, bias shift, narrow to DW.
// Build option: LSTM_SAT_EN saturates the narrowed preactivation.
module lstm_mac_unit
  import lstm_pkg::*;
#(
  parameter int DW   = 16,
  parameter int FW   = 8,
  parameter int ACCW = 34
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 en,
  input  logic                 bias,
  input  logic signed [DW-1:0] w,
  input  logic signed [DW-1:0] x,
  output logic signed [DW-1:0] pre
);

  logic signed [2*DW-1:0] prod;
  logic signed [ACCW-1:0] term;
  logic signed [ACCW-1:0] acc;
  logic signed [ACCW-1:0] shifted;

  assign prod = w * x;

  // bias is aligned to the product's 2*FW fraction
  always_comb begin
    term = bias ? (ACCW'(w) <<< FW) : ACCW'(prod);
  end

  always_ff @(posedge clk) begin
    if (rst) acc <= '0;
    else if (en) acc <= clr ? term : acc + term;
  end

  assign shifted = acc >>> FW;

`ifdef LSTM_SAT_EN
  assign pre = DW'(sat_narrow(64'(shifted), DW));
`else
  assign pre = DW'(shifted);
`endif

endmodule

// File: rtl/lstm_sigmoid.sv
// Piecewise-linear sigmoid: clamp(0.5 + x/4, 0, 1.0).
// Build option: none (LSTM_SAT_EN lives in the MAC datapath).
module lstm_sigmoid #(
  parameter int DW = 16,
  parameter int FW = 8
) (
  input  logic signed [DW-1:0] x,
  output logic signed [DW-1:0] y
);

  localparam logic signed [DW-1:0] ONE  = DW'(1 << FW);
  localparam logic signed [DW-1:0] HALF = DW'(1 << (FW - 1));

  logic signed [DW-1:0] q;

  assign q = (x >>> 2) + HALF;

  always_comb begin
    if (q < 0) y = '0;
    else if (q > ONE) y = ONE;
    else y = q;
  end

endmodule

// File: rtl/lstm_tanh.sv
// Hard tanh: clamp(x, -1.0, 1.0).
// Build option: none (LSTM_SAT_EN lives in the MAC datapath).
module lstm_tanh #(
  parameter int DW = 16,
  parameter int FW = 8
) (
  input  logic signed [DW-1:0] x,
  output logic signed [DW-1:0] y
);

  localparam logic signed [DW-1:0] ONE = DW'(1 << FW);

  always_comb begin
    if (x > ONE) y = ONE;
    else if (x < -ONE) y = -ONE;
    else y = x;
  end

endmodule

// File: rtl/lstm_seq_cell.sv
// Time-multiplexed LSTM cell: FSM, weight RAM, h/c state.
// Build option: LSTM_SAT_EN saturates c'/h' and preact narrowing.
module lstm_seq_cell
  import lstm_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int FRACT_WIDTH = 8,
  parameter int IN_DIM      = 1,
  parameter int HID_DIM     = 1,
  localparam int N  = IN_DIM + HID_DIM,
  localparam int AW = $clog2(4 * HID_DIM * (N + 1))
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [IN_DIM*DATA_WIDTH-1:0]  in_data,
  input  logic                          seq_start,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [HID_DIM*DATA_WIDTH-1:0] h_out,
  output logic [HID_DIM*DATA_WIDTH-1:0] c_out,
  input  logic                          w_we,
  input  logic [AW-1:0]                 w_addr,
  input  logic [DATA_WIDTH-1:0]         w_data,
  output logic                          busy
);

  localparam int DW    = DATA_WIDTH;
  localparam int FW    = FRACT_WIDTH;
  localparam int DEPTH = 4 * HID_DIM * (N + 1);
  localparam int KW    = $clog2(N + 1);
  localparam int JW    = (HID_DIM > 1) ? $clog2(HID_DIM) : 1;
  localparam int ACCW  = acc_width(DW, N);
  localparam int PW    = 2 * DW + 1;

  state_t state;
  state_t nxt;

  logic [KW-1:0] k;
  logic [1:0]    gate;
  logic [JW-1:0] j;
  logic          k_last;
  logic          g_last;
  logic          j_last;
  logic          fire;
  logic          ss_r;

  logic signed [DW-1:0] wram  [DEPTH];
  logic signed [DW-1:0] x_reg [IN_DIM];
  logic signed [DW-1:0] h_wk  [HID_DIM];
  logic signed [DW-1:0] c_wk  [HID_DIM];
  logic signed [DW-1:0] h_nxt [HID_DIM];
  logic signed [DW-1:0] c_nxt [HID_DIM];
  logic signed [DW-1:0] h_reg [HID_DIM];
  logic signed [DW-1:0] c_reg [HID_DIM];

  logic signed [DW-1:0] f_v, i_v, g_v, o_v;
  logic signed [DW-1:0] w_rd, opnd, pre;
  logic signed [DW-1:0] sig_y, tanh_y, tanh_in, act_y;
  logic signed [DW-1:0] c_j, c_pend, c_new, h_new;
  logic signed [PW-1:0] c_sum, h_sum;
  logic [AW-1:0]        ra;

  assign fire   = in_valid && (state == S_IDLE);
  assign k_last = (k == KW'(N));
  assign g_last = (gate == GATE_O);
  assign j_last = (j == JW'(HID_DIM - 1));

  assign in_ready  = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign out_valid = (state == S_OUT);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE:  if (in_valid) nxt = S_LOAD;
      S_LOAD:  nxt = S_MAC;
      S_MAC:   if (k_last) nxt = S_ACT;
      S_ACT:   nxt = g_last ? S_UPD_C : S_MAC;
      S_UPD_C: nxt = S_UPD_H;
      S_UPD_H: nxt = j_last ? S_OUT : S_MAC;
      S_OUT:   if (out_ready) nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || state == S_IDLE) begin
      k    <= '0;
      gate <= '0;
      j    <= '0;
    end else begin
      if (state == S_MAC) k <= k_last ? '0 : k + KW'(1);
      if (state == S_ACT) gate <= gate + 2'd1;
      if (state == S_UPD_H) j <= j_last ? '0 : j + JW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_we && state == S_IDLE && int'(w_addr) < DEPTH)
      wram[w_addr] <= w_data;
  end

  assign ra   = AW'(waddr(int'(gate), int'(j), int'(k), HID_DIM, N));
  assign w_rd = wram[ra];

  always_comb begin
    opnd = '0;
    for (int e = 0; e < IN_DIM; e++)
      if (int'(k) == e) opnd = x_reg[e];
    for (int u = 0; u < HID_DIM; u++)
      if (int'(k) == IN_DIM + u) opnd = h_wk[u];
  end

  always_comb begin
    c_j    = '0;
    c_pend = '0;
    for (int u = 0; u < HID_DIM; u++)
      if (JW'(u) == j) begin
        c_j    = c_wk[u];
        c_pend = c_nxt[u];
      end
  end

  lstm_mac_unit #(.DW(DW), .FW(FW), .ACCW(ACCW)) u_mac (
    .clk  (clk),
    .rst  (rst),
    .clr  (k == '0),
    .en   (state == S_MAC),
    .bias (k_last),
    .w    (w_rd),
    .x    (opnd),
    .pre  (pre)
  );

  // tanh is shared between the g gate and tanh(c')
  assign tanh_in = (state == S_UPD_H) ? c_pend : pre;
  assign act_y   = (gate == GATE_C) ? tanh_y : sig_y;

  lstm_sigmoid #(.DW(DW), .FW(FW)) u_sig (.x(pre), .y(sig_y));
  lstm_tanh #(.DW(DW), .FW(FW)) u_tanh (.x(tanh_in), .y(tanh_y));

  assign c_sum = ((PW'(f_v) * PW'(c_j)) >>> FW)
               + ((PW'(i_v) * PW'(g_v)) >>> FW);
  assign h_sum = (PW'(o_v) * PW'(tanh_y)) >>> FW;

`ifdef LSTM_SAT_EN
  assign c_new = DW'(sat_narrow(64'(c_sum), DW));
  assign h_new = DW'(sat_narrow(64'(h_sum), DW));
`else
  assign c_new = DW'(c_sum);
  assign h_new = DW'(h_sum);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      ss_r <= 1'b0;
      f_v  <= '0;
      i_v  <= '0;
      g_v  <= '0;
      o_v  <= '0;
      for (int e = 0; e < IN_DIM; e++) x_reg[e] <= '0;
      for (int u = 0; u < HID_DIM; u++) begin
        h_wk[u]  <= '0;
        c_wk[u]  <= '0;
        h_nxt[u] <= '0;
        c_nxt[u] <= '0;
        h_reg[u] <= '0;
        c_reg[u] <= '0;
      end
    end else begin
      if (fire) begin
        ss_r <= seq_start;
        for (int e = 0; e < IN_DIM; e++)
          x_reg[e] <= in_data[e*DW +: DW];
      end
      if (state == S_LOAD)
        for (int u = 0; u < HID_DIM; u++) begin
          h_wk[u] <= ss_r ? '0 : h_reg[u];
          c_wk[u] <= ss_r ? '0 : c_reg[u];
        end
      if (state == S_ACT)
        unique case (gate)
          GATE_F: f_v <= act_y;
          GATE_I: i_v <= act_y;
          GATE_C: g_v <= act_y;
          GATE_O: o_v <= act_y;
        endcase
      if (state == S_UPD_C)
        for (int u = 0; u < HID_DIM; u++)
          if (JW'(u) == j) c_nxt[u] <= c_new;
      if (state == S_UPD_H) begin
        for (int u = 0; u < HID_DIM; u++)
          if (JW'(u) == j) h_nxt[u] <= h_new;
        // last unit: commit the whole vector as OUT is entered
        if (j_last)
          for (int u = 0; u < HID_DIM; u++) begin
            h_reg[u] <= (JW'(u) == j) ? h_new : h_nxt[u];
            c_reg[u] <= c_nxt[u];
          end
      end
    end
  end

  for (genvar u = 0; u < HID_DIM; u++) begin : g_out
    assign h_out[u*DW +: DW] = h_reg[u];
    assign c_out[u*DW +: DW] = c_reg[u];
  end

endmodule

// File: tb/tb_lstm_seq_cell.sv
// Randomized bench for lstm_seq_cell against a plain-arithmetic LSTM model.
// Honors LSTM_SAT_EN in the model's narrowing.
module tb_lstm_seq_cell;

  localparam int DW    = 16;
  localparam int IN    = 1;
  localparam int HID   = 1;
  localparam int N     = IN + HID;
  localparam int DEPTH = 4 * HID * (N + 1);
  localparam int AW    = $clog2(DEPTH);

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [IN*DW-1:0]  in_data = '0;
  logic              seq_start = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [HID*DW-1:0] h_out;
  logic [HID*DW-1:0] c_out;
  logic              w_we = 1'b0;
  logic [AW-1:0]     w_addr = '0;
  logic [DW-1:0]     w_data = '0;
  logic              busy;

  int n_cmp = 0;
  int n_err = 0;

  longint wt [DEPTH];
  longint mh [HID];
  longint mc [HID];
  longint xin [IN];

  lstm_seq_cell dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .seq_start (seq_start),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .h_out     (h_out),
    .c_out     (c_out),
    .w_we      (w_we),
    .w_addr    (w_addr),
    .w_data    (w_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic longint nar(input longint v);
`ifdef LSTM_SAT_EN
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
`else
    return longint'(shortint'(v));
`endif
  endfunction

  function automatic longint sigm(input longint x);
    longint y;
    y = 128 + (x >>> 2);
    if (y < 0) y = 0;
    if (y > 256) y = 256;
    return y;
  endfunction

  function automatic longint tnh(input longint x);
    if (x > 256) return 256;
    if (x < -256) return -256;
    return x;
  endfunction

  task automatic model_step(input bit ss);
    longint hp [HID];
    longint cp [HID];
    longint gv [4];
    longint acc, w, c, h;
    for (int u = 0; u < HID; u++) begin
      hp[u] = ss ? 0 : mh[u];
      cp[u] = ss ? 0 : mc[u];
    end
    for (int u = 0; u < HID; u++) begin
      for (int g = 0; g < 4; g++) begin
        acc = 0;
        for (int kk = 0; kk <= N; kk++) begin
          w = wt[(g * HID + u) * (N + 1) + kk];
          if (kk < IN) acc += w * xin[kk];
          else if (kk < N) acc += w * hp[kk - IN];
          else acc += w * 256;
        end
        acc = nar(acc >>> 8);
        gv[g] = (g == 2) ? tnh(acc) : sigm(acc);
      end
      c = nar(((gv[0] * cp[u]) >>> 8) + ((gv[1] * gv[2]) >>> 8));
      h = nar((gv[3] * tnh(c)) >>> 8);
      mh[u] = h;
      mc[u] = c;
    end
  endtask

  function automatic logic [HID*DW-1:0] exp_h();
    logic [HID*DW-1:0] r;
    for (int u = 0; u < HID; u++) r[u*DW +: DW] = DW'(mh[u]);
    return r;
  endfunction

  function automatic logic [HID*DW-1:0] exp_c();
    logic [HID*DW-1:0] r;
    for (int u = 0; u < HID; u++) r[u*DW +: DW] = DW'(mc[u]);
    return r;
  endfunction

  task automatic wr(input int a, input longint d);
    w_we   = 1'b1;
    w_addr = AW'(a);
    w_data = DW'(d);
    tick();
    w_we = 1'b0;
    wt[a] = longint'($signed(w_data));
  endtask

  task automatic fill(input longint wx, input longint wh, input longint b);
    for (int a = 0; a < DEPTH; a++) begin
      if (a % (N + 1) < IN) wr(a, wx);
      else if (a % (N + 1) < N) wr(a, wh);
      else wr(a, b);
    end
  endtask

  task automatic accept(input logic [IN*DW-1:0] x, input bit ss);
    in_valid  = 1'b1;
    in_data   = x;
    seq_start = ss;
    tick();
    in_valid  = 1'b0;
    seq_start = 1'b0;
    for (int e = 0; e < IN; e++) xin[e] = longint'($signed(x[e*DW +: DW]));
    model_step(ss);
  endtask

  task automatic wait_out(inout int lat);
    while (!out_valid && lat < 200) begin
      tick();
      lat++;
    end
  endtask

  task automatic apply(input logic [IN*DW-1:0] x, input bit ss, output int lat);
    accept(x, ss);
    lat = 0;
    wait_out(lat);
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    int cnt;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    for (int u = 0; u < HID; u++) begin
      mh[u] = 0;
      mc[u] = 0;
    end
    cnt = {in_ready, out_valid, busy};
    n_cmp++;
    if (cnt !== 4) begin
      n_err++;
      $display("FAIL reset_flags: got rdy/vld/busy=%b want 100", cnt[2:0]);
    end
    n_cmp++;
    if (h_out !== '0 || c_out !== '0) begin
      n_err++;
      $display("FAIL reset_state: got h=%h c=%h want 0", h_out, c_out);
    end
  endtask

  task automatic test_zero_input();
    int lat;
    fill(256, 256, 0);
    apply('0, 1'b1, lat);
    n_cmp++;
    if (lat !== 19) begin
      n_err++;
      $display("FAIL zero_latency: got %0d want 19", lat);
    end
    n_cmp++;
    if (h_out !== 16'h0000 || c_out !== 16'h0000) begin
      n_err++;
      $display("FAIL zero_result: got h=%h c=%h want 0000/0000", h_out, c_out);
    end
    release_out();
  endtask

  task automatic test_stall();
    int lat;
    int bad;
    apply(16'h0100, 1'b0, lat);
    bad = 0;
    for (int t = 0; t < 10; t++) begin
      tick();
      if (!out_valid || in_ready || !busy || h_out !== exp_h() || c_out !== exp_c())
        bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL stall_hold: %0d bad cycles h=%h c=%h want h=%h c=%h",
               bad, h_out, c_out, exp_h(), exp_c());
    end
    release_out();
    n_cmp++;
    if (!in_ready || out_valid || busy) begin
      n_err++;
      $display("FAIL stall_release: rdy=%b vld=%b busy=%b want 1/0/0",
               in_ready, out_valid, busy);
    end
  endtask

  task automatic test_recurrent();
    int lat;
    logic [HID*DW-1:0] h1, c1;
    apply('0, 1'b1, lat);
    h1 = exp_h();
    c1 = exp_c();
    release_out();
    apply(16'h0100, 1'b0, lat);
    n_cmp++;
    if (lat !== 19 || h_out !== exp_h() || c_out !== exp_c()) begin
      n_err++;
      $display("FAIL recur_step: lat=%0d h=%h c=%h want 19 h=%h c=%h",
               lat, h_out, c_out, exp_h(), exp_c());
    end
    release_out();
    apply(16'h0100, 1'b0, lat);
    n_cmp++;
    if (h_out !== exp_h() || c_out !== exp_c()) begin
      n_err++;
      $display("FAIL recur_step2: h=%h c=%h want h=%h c=%h",
               h_out, c_out, exp_h(), exp_c());
    end
    release_out();
    apply('0, 1'b1, lat);
    n_cmp++;
    if (h_out !== h1 || c_out !== c1) begin
      n_err++;
      $display("FAIL recur_restart: h=%h c=%h want h=%h c=%h", h_out, c_out, h1, c1);
    end
    release_out();
  endtask

  task automatic test_narrow();
    int lat;
    logic [DW-1:0] want_c;
`ifdef LSTM_SAT_EN
    want_c = 16'h0100;
`else
    want_c = 16'h00A0;
`endif
    fill(0, 0, 0);
    wr(0, 32767);
    wr(2 * (N + 1) + N, 256);
    apply(16'h7FFF, 1'b1, lat);
    n_cmp++;
    if (h_out !== 16'h0040 || c_out !== 16'h0080) begin
      n_err++;
      $display("FAIL narrow_seed: h=%h c=%h want 0040/0080", h_out, c_out);
    end
    release_out();
    apply(16'h7FFF, 1'b0, lat);
    n_cmp++;
    if (c_out !== want_c || h_out !== exp_h()) begin
      n_err++;
      $display("FAIL narrow_fgate: c=%h h=%h want c=%h h=%h",
               c_out, h_out, want_c, exp_h());
    end
    release_out();
  endtask

  task automatic test_busy_write();
    int lat;
    fill(128, 128, 0);
    apply(16'h0100, 1'b1, lat);
    release_out();
    accept(16'h0100, 1'b0);
    lat = 0;
    for (int t = 0; t < 3; t++) begin
      tick();
      lat++;
    end
    w_we   = 1'b1;
    w_addr = '0;
    w_data = 16'h7FFF;
    tick();
    lat++;
    w_we = 1'b0;
    wait_out(lat);
    n_cmp++;
    if (lat !== 19 || h_out !== exp_h() || c_out !== exp_c()) begin
      n_err++;
      $display("FAIL busy_write_dropped: lat=%0d h=%h c=%h want 19 h=%h c=%h",
               lat, h_out, c_out, exp_h(), exp_c());
    end
    release_out();
    wr(0, 32767);
    apply(16'h0100, 1'b0, lat);
    n_cmp++;
    if (h_out !== exp_h() || c_out !== exp_c()) begin
      n_err++;
      $display("FAIL idle_write_taken: h=%h c=%h want h=%h c=%h",
               h_out, c_out, exp_h(), exp_c());
    end
    release_out();
  endtask

  task automatic test_mid_reset();
    int lat;
    int seen;
    accept(16'h0180, 1'b0);
    for (int t = 0; t < 5; t++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int u = 0; u < HID; u++) begin
      mh[u] = 0;
      mc[u] = 0;
    end
    n_cmp++;
    if (!in_ready || out_valid || busy || h_out !== '0 || c_out !== '0) begin
      n_err++;
      $display("FAIL midreset_state: rdy=%b vld=%b busy=%b h=%h c=%h want 1/0/0/0/0",
               in_ready, out_valid, busy, h_out, c_out);
    end
    seen = 0;
    for (int t = 0; t < 25; t++) begin
      tick();
      if (out_valid) seen++;
    end
    n_cmp++;
    if (seen != 0) begin
      n_err++;
      $display("FAIL midreset_novalid: got %0d valid cycles want 0", seen);
    end
    apply(16'h0180, 1'b0, lat);
    n_cmp++;
    if (lat !== 19 || h_out !== exp_h() || c_out !== exp_c()) begin
      n_err++;
      $display("FAIL midreset_next: lat=%0d h=%h c=%h want 19 h=%h c=%h",
               lat, h_out, c_out, exp_h(), exp_c());
    end
    release_out();
  endtask

  task automatic test_random();
    int lat;
    logic [IN*DW-1:0] x;
    bit ss;
    for (int v = 0; v < 16; v++) begin
      if (v % 4 == 0)
        for (int a = 0; a < DEPTH; a++) begin
          if (v == 12) wr(a, longint'($urandom_range(0, 65535)) - 32768);
          else wr(a, longint'($urandom_range(0, 1023)) - 512);
        end
      for (int e = 0; e < IN; e++)
        x[e*DW +: DW] = (v % 3 == 2) ? DW'($urandom) : DW'($urandom_range(0, 2047) - 1024);
      ss = ($urandom_range(0, 3) == 0);
      apply(x, ss, lat);
      n_cmp++;
      if (lat !== 19 || h_out !== exp_h() || c_out !== exp_c()) begin
        n_err++;
        $display("FAIL random_%0d: lat=%0d h=%h c=%h want 19 h=%h c=%h",
                 v, lat, h_out, c_out, exp_h(), exp_c());
      end
      release_out();
    end
  endtask

  initial begin
    test_reset();
    test_zero_input();
    test_stall();
    test_recurrent();
    test_narrow();
    test_busy_write();
    test_mid_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
